// File: rtl/instr_loader_pkg.sv
// Shared encodings for the instruction loader: command classes, MIPS opcode/func constants, FSM states.
// The PAD state only exists when INSTR_LOADER_NOP_PAD_EN is defined.
package instr_loader_pkg;

    localparam logic [2:0] CMD_ADD     = 3'd0;
    localparam logic [2:0] CMD_SUB     = 3'd1;
    localparam logic [2:0] CMD_ORI     = 3'd2;
    localparam logic [2:0] CMD_LW      = 3'd3;
    localparam logic [2:0] CMD_SW      = 3'd4;
    localparam logic [2:0] CMD_BEQ     = 3'd5;
    localparam logic [2:0] CMD_J       = 3'd6;
    localparam logic [2:0] CMD_ILLEGAL = 3'd7;

    // Same constants the Control decoder matches against
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

`ifdef INSTR_LOADER_NOP_PAD_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL, S_PAD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;
`endif

endpackage

// File: rtl/instr_loader_encode.sv
// Combinational MIPS encoder: maps a command class and its fields to a 32-bit instruction word.
module instr_encode
    import instr_loader_pkg::*;
(
    input  logic [2:0]  CmdOp,
    input  logic [4:0]  CmdRs,
    input  logic [4:0]  CmdRt,
    input  logic [4:0]  CmdRd,
    input  logic [25:0] CmdImm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (CmdOp)
            CMD_ADD: word = {OP_RTYPE, CmdRs, CmdRt, CmdRd, 5'd0, FUNC_ADD};
            CMD_SUB: word = {OP_RTYPE, CmdRs, CmdRt, CmdRd, 5'd0, FUNC_SUB};
            CMD_ORI: word = {OP_ORI, CmdRs, CmdRt, CmdImm[15:0]};
            CMD_LW:  word = {OP_LW,  CmdRs, CmdRt, CmdImm[15:0]};
            CMD_SW:  word = {OP_SW,  CmdRs, CmdRt, CmdImm[15:0]};
            CMD_BEQ: word = {OP_BEQ, CmdRs, CmdRt, CmdImm[15:0]};
            CMD_J:   word = {OP_J, CmdImm};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Streams encoded instructions into instruction memory, one command per two cycles.
// Optional NOP padding to the end of memory is enabled with INSTR_LOADER_NOP_PAD_EN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       CmdValid,
    output logic                       CmdReady,
    input  logic [2:0]                 CmdOp,
    input  logic [4:0]                 CmdRs,
    input  logic [4:0]                 CmdRt,
    input  logic [4:0]                 CmdRd,
    input  logic [25:0]                CmdImm,
    input  logic                       Clear,
    input  logic                       Finish,
    output logic                       MemWE,
    output logic [31:0]                MemAddr,
    output logic [31:0]                MemWData,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Error
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          finish_req;
    logic          accept;
    logic [CW-1:0] count_inc;

    instr_encode u_encode (
        .CmdOp   (CmdOp),
        .CmdRs   (CmdRs),
        .CmdRt   (CmdRt),
        .CmdRd   (CmdRd),
        .CmdImm  (CmdImm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    function automatic logic [31:0] word_addr(input logic [CW-1:0] idx);
        return BASE_ADDR + (32'(idx) << 2);
    endfunction

`ifdef INSTR_LOADER_NOP_PAD_EN
    assign finish_req = Finish && (state == S_IDLE) && !Full;
`else
    logic unused_finish;
    assign unused_finish = Finish;
    assign finish_req    = 1'b0;
`endif

    assign Full      = (Count == CW'(DEPTH));
    assign CmdReady  = (state == S_IDLE) && !Full && !Clear && !finish_req;
    assign accept    = CmdValid && CmdReady;
    assign count_inc = Count + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            Count    <= '0;
            MemWE    <= 1'b0;
            MemAddr  <= BASE_ADDR;
            MemWData <= 32'h0;
            Error    <= 1'b0;
        end else begin
            MemWE <= 1'b0;
            Error <= 1'b0;
            if (Clear) begin
                // Clear beats everything, including an in-flight write
                state   <= S_IDLE;
                Count   <= '0;
                MemAddr <= BASE_ADDR;
            end else begin
                case (state)
                    S_IDLE: begin
`ifdef INSTR_LOADER_NOP_PAD_EN
                        if (finish_req) begin
                            state    <= S_PAD;
                            MemWE    <= 1'b1;
                            MemAddr  <= word_addr(Count);
                            MemWData <= NOP_WORD;
                        end else
`endif
                        if (accept) begin
                            if (enc_illegal) begin
                                Error <= 1'b1;
                            end else begin
                                state    <= S_WRITE;
                                MemWE    <= 1'b1;
                                MemAddr  <= word_addr(Count);
                                MemWData <= enc_word;
                            end
                        end
                    end
                    S_WRITE: begin
                        Count <= count_inc;
                        state <= (count_inc == CW'(DEPTH)) ? S_FULL : S_IDLE;
                    end
`ifdef INSTR_LOADER_NOP_PAD_EN
                    S_PAD: begin
                        Count <= count_inc;
                        if (count_inc == CW'(DEPTH)) begin
                            state <= S_FULL;
                        end else begin
                            MemWE    <= 1'b1;
                            MemAddr  <= word_addr(count_inc);
                            MemWData <= NOP_WORD;
                        end
                    end
`endif
                    S_FULL:  state <= S_FULL;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a DEPTH=8 instance for the main flow and a DEPTH=2 instance for the fill test.
module tb_instr_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    wr_t exp_q[$];
    wr_t s_exp_q[$];

    // main instance, DEPTH=8
    logic        CmdValid = 0, Clear = 0, Finish = 0;
    logic [2:0]  CmdOp = 0;
    logic [4:0]  CmdRs = 0, CmdRt = 0, CmdRd = 0;
    logic [25:0] CmdImm = 0;
    logic        CmdReady, MemWE, Full, Error;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  Count;

    instr_loader #(.DEPTH(8), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst(rst), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdRs(CmdRs), .CmdRt(CmdRt), .CmdRd(CmdRd), .CmdImm(CmdImm),
        .Clear(Clear), .Finish(Finish), .MemWE(MemWE), .MemAddr(MemAddr),
        .MemWData(MemWData), .Count(Count), .Full(Full), .Error(Error)
    );

    // small instance, DEPTH=2
    logic        s_valid = 0, s_clear = 0, s_finish = 0;
    logic [2:0]  s_op = 0;
    logic [4:0]  s_rs = 0, s_rt = 0, s_rd = 0;
    logic [25:0] s_imm = 0;
    logic        s_ready, s_we, s_full, s_error;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_count;

    instr_loader #(.DEPTH(2), .BASE_ADDR(32'h0)) u_small (
        .clk(clk), .rst(rst), .CmdValid(s_valid), .CmdReady(s_ready),
        .CmdOp(s_op), .CmdRs(s_rs), .CmdRt(s_rt), .CmdRd(s_rd), .CmdImm(s_imm),
        .Clear(s_clear), .Finish(s_finish), .MemWE(s_we), .MemAddr(s_addr),
        .MemWData(s_wdata), .Count(s_count), .Full(s_full), .Error(s_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every presented write must match the next expected write
    always @(negedge clk) begin
        if (MemWE === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("main_unexpected_write", MemAddr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("main_wr_addr", MemAddr, e.addr);
                chk("main_wr_data", MemWData, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (s_we === 1'b1) begin
            if (s_exp_q.size() == 0) begin
                chk("small_unexpected_write", s_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = s_exp_q.pop_front();
                chk("small_wr_addr", s_addr, e.addr);
                chk("small_wr_data", s_wdata, e.data);
            end
        end
    end

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Returns at posedge+1 of the accepting edge (the WRITE cycle for a legal command)
    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm);
        int n = 0;
        @(negedge clk);
        CmdOp = op; CmdRs = rs; CmdRt = rt; CmdRd = rd; CmdImm = imm;
        CmdValid = 1'b1;
        #1;
        while (!CmdReady && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!CmdReady) chk("main_send_timeout", {31'd0, CmdReady}, 32'd1);
        else @(posedge clk);
        #1 CmdValid = 1'b0;
    endtask

    task automatic s_send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [25:0] imm);
        int n = 0;
        @(negedge clk);
        s_op = op; s_rs = rs; s_rt = rt; s_rd = rd; s_imm = imm;
        s_valid = 1'b1;
        #1;
        while (!s_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!s_ready) chk("small_send_timeout", {31'd0, s_ready}, 32'd1);
        else @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        Clear = 1'b1;
        @(posedge clk);
        #1 Clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_memwe", {31'd0, MemWE}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'h0);
        chk("rst_memwdata", MemWData, 32'h0);
        chk("rst_full", {31'd0, Full}, 32'd0);
        chk("rst_error", {31'd0, Error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, CmdReady}, 32'd1);

        // single ADD
        expect_wr(32'h0, 32'h0022_1820);
        send(3'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        @(negedge clk);
        chk("add_memwe", {31'd0, MemWE}, 32'd1);
        chk("add_count_during_write", 32'(Count), 32'd0);
        @(negedge clk);
        chk("add_count", 32'(Count), 32'd1);
        chk("add_memwe_after", {31'd0, MemWE}, 32'd0);
        pulse_clear();
        @(negedge clk);
        chk("clear_count", 32'(Count), 32'd0);

        // four-command sequence
        expect_wr(32'h0, 32'h3405_00FF);
        expect_wr(32'h4, 32'h8FA8_0004);
        expect_wr(32'h8, 32'h1022_FFFF);
        expect_wr(32'hC, 32'h0800_0010);
        send(3'd2, 5'd0,  5'd5, 5'd0, 26'h00FF);
        send(3'd3, 5'd29, 5'd8, 5'd0, 26'h0004);
        send(3'd5, 5'd1,  5'd2, 5'd0, 26'hFFFF);
        send(3'd6, 5'd0,  5'd0, 5'd0, 26'h10);
        @(negedge clk); @(negedge clk);
        chk("seq_count", 32'(Count), 32'd4);

        // illegal command
        send(3'd7, 5'd1, 5'd1, 5'd1, 26'd0);
        @(negedge clk);
        chk("illegal_error", {31'd0, Error}, 32'd1);
        chk("illegal_memwe", {31'd0, MemWE}, 32'd0);
        @(negedge clk);
        chk("illegal_error_pulse", {31'd0, Error}, 32'd0);
        chk("illegal_count", 32'(Count), 32'd4);
        expect_wr(32'h10, 32'hAC64_0010);
        send(3'd4, 5'd3, 5'd4, 5'd0, 26'h10);
        @(negedge clk); @(negedge clk);
        chk("sw_count", 32'(Count), 32'd5);

        // Clear during WRITE
        expect_wr(32'h14, 32'h0000_0820);
        send(3'd0, 5'd0, 5'd0, 5'd1, 26'd0);
        Clear = 1'b1;
        @(posedge clk);
        #1 Clear = 1'b0;
        @(negedge clk);
        chk("clrw_memwe", {31'd0, MemWE}, 32'd0);
        chk("clrw_count", 32'(Count), 32'd0);
        expect_wr(32'h0, 32'h3443_1234);
        send(3'd2, 5'd2, 5'd3, 5'd0, 26'h1234);
        pulse_clear();

        expect_wr(32'h0, 32'h0022_1820);
        expect_wr(32'h4, 32'h0085_3022);
        expect_wr(32'h8, 32'h0BFF_FFFF);
        send(3'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        send(3'd1, 5'd4, 5'd5, 5'd6, 26'd0);
        send(3'd6, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFF);
        @(posedge clk); #1;

`ifdef INSTR_LOADER_NOP_PAD_EN
        // Finish together with a valid command: Finish wins
        for (int i = 0; i < 5; i++) expect_wr(32'hC + 32'(4 * i), 32'h0);
        @(negedge clk);
        Finish = 1'b1; CmdValid = 1'b1; CmdOp = 3'd0;
        #1 chk("pad_finish_ready", {31'd0, CmdReady}, 32'd0);
        @(posedge clk);
        #1 Finish = 1'b0; CmdValid = 1'b0;
        begin
            int n = 0;
            while (!Full && n < 30) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        chk("pad_full", {31'd0, Full}, 32'd1);
        chk("pad_count", 32'(Count), 32'd8);
        chk("pad_ready", {31'd0, CmdReady}, 32'd0);
        @(negedge clk); Finish = 1'b1;
        @(negedge clk); Finish = 1'b0;
        chk("pad_full_finish_count", 32'(Count), 32'd8);
        pulse_clear();
        // rst mid-PAD
        expect_wr(32'h0, 32'h0022_1820);
        send(3'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        @(posedge clk); #1;
        Finish = 1'b1;
        expect_wr(32'h4, 32'h0);
        @(posedge clk);
        #1 Finish = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstpad_memwe", {31'd0, MemWE}, 32'd0);
        chk("rstpad_count", 32'(Count), 32'd0);
`else
        // Finish is ignored without padding
        @(negedge clk);
        Finish = 1'b1;
        #1 chk("nopad_finish_ready", {31'd0, CmdReady}, 32'd1);
        @(posedge clk);
        #1 Finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("nopad_count", 32'(Count), 32'd3);
        // rst mid-WRITE
        expect_wr(32'hC, 32'h0022_1820);
        send(3'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstw_memwe", {31'd0, MemWE}, 32'd0);
        chk("rstw_count", 32'(Count), 32'd0);
`endif

        // DEPTH=2 fill, blocked third command, Clear releases it
        s_exp_q.push_back('{addr: 32'h0, data: 32'h0022_1820});
        s_exp_q.push_back('{addr: 32'h4, data: 32'h0085_3022});
        s_send(3'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        s_send(3'd1, 5'd4, 5'd5, 5'd6, 26'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("small_full", {31'd0, s_full}, 32'd1);
        chk("small_count", 32'(s_count), 32'd2);
        s_op = 3'd6; s_imm = 26'h3FF_FFFF; s_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("small_ready_blocked", {31'd0, s_ready}, 32'd0);
        s_exp_q.push_back('{addr: 32'h0, data: 32'h0BFF_FFFF});
        s_clear = 1'b1;
        #1 chk("small_clear_prio", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1 s_clear = 1'b0;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("small_count_after", 32'(s_count), 32'd1);
        chk("small_full_after", {31'd0, s_full}, 32'd0);

        repeat (3) @(negedge clk);
        chk("main_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("small_queue_empty", 32'(s_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
